// File: rtl/timer_irq_sched_pkg.sv
// Shared definitions for the timer interrupt scheduler.
// Register word offsets (block decodes addr[4:0]), FSM encodings, request levels.
// No logic here; imported by the scheduler and its picker.
package timer_irq_sched_pkg;

    localparam logic [4:0] ADDR_CTRL  = 5'h00;
    localparam logic [4:0] ADDR_MASK  = 5'h04;
    localparam logic [4:0] ADDR_PEND  = 5'h08;
    localparam logic [4:0] ADDR_CLAIM = 5'h0C;
    localparam logic [4:0] ADDR_EOI   = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic INT_ASSERT   = 1'b1;
    localparam logic INT_DEASSERT = 1'b0;

endpackage

// File: rtl/irq_rr_picker.sv
// Picks one eligible interrupt source: lowest index, or first at/after rr_ptr (wrapping).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the winner.
module irq_rr_picker
    import timer_irq_sched_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               rr_mode,
    output logic [ID_W-1:0]    win_idx,
    output logic               win_vld
);

    logic [ID_W-1:0]    start;
    logic [NUM_SRC-1:0] hi_mask;
    logic [NUM_SRC-1:0] cand;

    // Search the sources at/after the start point first; if none, the lowest
    // eligible index is the wrapped winner (and the fixed-mode winner).
    always_comb begin
        start   = rr_mode ? rr_ptr : '0;
        hi_mask = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            hi_mask[k] = (ID_W'(k) >= start);
        end
        cand    = ((elig & hi_mask) != '0) ? (elig & hi_mask) : elig;
        win_vld = (elig != '0);
        win_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win_idx = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/timer_irq_sched.sv
// Timer interrupt scheduler: edge-captures sources, masks, arbitrates, holds one until EOI.
// Latency: source edge -> PEND 1 cycle, PEND -> int_req_o 1 cycle; reads are combinational.
// Backpressure: a granted request is held until int_ack_i; later edges accumulate in PEND.
module timer_irq_sched
    import timer_irq_sched_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    input  logic [3:0]         sel_i,
    output logic [31:0]        data_o,
    input  logic [NUM_SRC-1:0] src_int_i,
    output logic               int_req_o,
    output logic [ID_W-1:0]    int_id_o,
    input  logic               int_ack_i,
    output logic               busy_o
);

    logic [1:0]         ctrl, ctrl_d;
    logic [NUM_SRC-1:0] mask, mask_d;
    logic [NUM_SRC-1:0] pend, pend_d;
    logic [NUM_SRC-1:0] src_q, rise, w1c, ack_clr, act_vec, elig;
    logic [ID_W-1:0]    act_id, rr_ptr, win_idx;
    logic               win_vld;
    logic               wr_ctrl, wr_mask, wr_pend, wr_eoi, act_keep;
    logic [4:0]         reg_addr;
    state_t             state;

    assign reg_addr = addr_i[4:0];

    // Bus decode and next values of the software-visible registers; the
    // active source stays requested only if it is still eligible after this cycle's writes.
    always_comb begin
        wr_ctrl  = we_i && sel_i[0] && (reg_addr == ADDR_CTRL);
        wr_mask  = we_i && sel_i[0] && (reg_addr == ADDR_MASK);
        wr_pend  = we_i && sel_i[0] && (reg_addr == ADDR_PEND);
        wr_eoi   = we_i && sel_i[0] && (reg_addr == ADDR_EOI);
        rise     = src_int_i & ~src_q;
        ctrl_d   = wr_ctrl ? data_i[1:0] : ctrl;
        mask_d   = wr_mask ? data_i[NUM_SRC-1:0] : mask;
        w1c      = wr_pend ? data_i[NUM_SRC-1:0] : '0;
        act_vec  = (act_id != '0) ? (NUM_SRC'(1) << (act_id - ID_W'(1))) : '0;
        ack_clr  = ((state == ST_REQ) && int_ack_i) ? act_vec : '0;
        // A new edge overrides a same-cycle software or ack clear.
        pend_d   = (pend & ~w1c & ~ack_clr) | rise;
        act_keep = ctrl_d[0] && ((act_vec & mask_d & pend_d) != '0);
        elig     = ctrl[0] ? (pend & mask) : '0;
    end

    irq_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .elig    (elig),
        .rr_ptr  (rr_ptr),
        .rr_mode (ctrl[1]),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Register file, edge capture and service FSM with registered request/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            mask      <= '0;
            pend      <= '0;
            src_q     <= '0;
            act_id    <= '0;
            rr_ptr    <= '0;
            state     <= ST_IDLE;
            int_req_o <= INT_DEASSERT;
            busy_o    <= 1'b0;
        end else begin
            ctrl  <= ctrl_d;
            mask  <= mask_d;
            pend  <= pend_d;
            src_q <= src_int_i;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        act_id    <= win_idx + ID_W'(1);
                        state     <= ST_REQ;
                        int_req_o <= INT_ASSERT;
                    end
                end
                ST_REQ: begin
                    if (int_ack_i) begin
                        state     <= ST_SERVE;
                        int_req_o <= INT_DEASSERT;
                        busy_o    <= 1'b1;
                    end else if (!act_keep) begin
                        act_id    <= '0;
                        state     <= ST_IDLE;
                        int_req_o <= INT_DEASSERT;
                    end
                end
                ST_SERVE: begin
                    if (wr_eoi) begin
                        // Next round-robin search starts just past the serviced source.
                        rr_ptr <= (act_id == ID_W'(NUM_SRC)) ? '0 : act_id;
                        act_id <= '0;
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    act_id    <= '0;
                    state     <= ST_IDLE;
                    int_req_o <= INT_DEASSERT;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read mux; unmapped offsets and EOI read as zero.
    always_comb begin
        data_o = '0;
        if (!rst) begin
            case (reg_addr)
                ADDR_CTRL:  data_o[1:0]         = ctrl;
                ADDR_MASK:  data_o[NUM_SRC-1:0] = mask;
                ADDR_PEND:  data_o[NUM_SRC-1:0] = pend;
                ADDR_CLAIM: data_o[ID_W-1:0]    = act_id;
                default:    data_o              = '0;
            endcase
        end
    end

    assign int_id_o = act_id;

    logic unused_bits;
    assign unused_bits = &{1'b0, addr_i[31:5], data_i[31:NUM_SRC], sel_i[3:1]};

endmodule

// File: tb/tb_timer_irq_sched.sv
module tb_timer_irq_sched;
    import timer_irq_sched_pkg::*;

    localparam int N  = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [3:0]    sel_i;
    logic [31:0]   data_o;
    logic [N-1:0]  src_int_i;
    logic          int_req_o;
    logic [IW-1:0] int_id_o;
    logic          int_ack_i;
    logic          busy_o;

    // standalone picker under unit test
    logic [N-1:0]  pk_elig;
    logic [IW-1:0] pk_ptr;
    logic          pk_mode;
    logic [IW-1:0] pk_idx;
    logic          pk_vld;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    timer_irq_sched #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .sel_i     (sel_i),
        .data_o    (data_o),
        .src_int_i (src_int_i),
        .int_req_o (int_req_o),
        .int_id_o  (int_id_o),
        .int_ack_i (int_ack_i),
        .busy_o    (busy_o)
    );

    irq_rr_picker #(.NUM_SRC(N), .ID_W(IW)) u_pk (
        .elig    (pk_elig),
        .rr_ptr  (pk_ptr),
        .rr_mode (pk_mode),
        .win_idx (pk_idx),
        .win_vld (pk_vld)
    );

    typedef struct {
        logic [2:0] elig;
        logic [2:0] ptr;
        logic       mode;
        logic       vld;
        logic [2:0] idx;
    } pk_vec_t;

    pk_vec_t pk_tab[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        we_i   = 1'b1;
        addr_i = {27'b0, a};
        data_i = d;
        sel_i  = s;
        tick();
        we_i   = 1'b0;
        sel_i  = 4'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr_i = {27'b0, a};
        #1;
        chk(name, data_o, exp);
    endtask

    task automatic pulse(input logic [N-1:0] v);
        src_int_i = v;
        tick();
        src_int_i = '0;
    endtask

    task automatic ack_cycle();
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
    endtask

    task automatic eoi();
        bus_wr(ADDR_EOI, 32'h1, 4'b0001);
    endtask

    task automatic wait_req(input string name, input logic [IW-1:0] exp_id);
        for (int i = 0; i < 20 && !int_req_o; i++) tick();
        chk({name, "_req"}, int_req_o, 1);
        chk({name, "_id"}, int_id_o, exp_id);
    endtask

    task automatic cleanup();
        bus_wr(ADDR_CTRL, 32'h0, 4'b0001);
        bus_wr(ADDR_PEND, 32'h7, 4'b0001);
    endtask

    // reference arbiter: smallest priority distance wins
    function automatic logic [3:0] ref_pick(input logic [2:0] e, input logic [2:0] p, input logic m);
        int best  = -1;
        int bestd = 1000;
        for (int i = 0; i < N; i++) begin
            if (e[i]) begin
                int d;
                d = m ? ((i - int'(p) + N) % N) : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return (best < 0) ? 4'b0 : {1'b1, 3'(best)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [3:0] exp_pk;

        pk_tab[0] = '{3'b000, 3'd0, 1'b0, 1'b0, 3'd0};
        pk_tab[1] = '{3'b110, 3'd0, 1'b0, 1'b1, 3'd1};
        pk_tab[2] = '{3'b111, 3'd2, 1'b0, 1'b1, 3'd0};
        pk_tab[3] = '{3'b111, 3'd2, 1'b1, 1'b1, 3'd2};
        pk_tab[4] = '{3'b011, 3'd2, 1'b1, 1'b1, 3'd0};
        pk_tab[5] = '{3'b100, 3'd0, 1'b1, 1'b1, 3'd2};
        pk_tab[6] = '{3'b010, 3'd1, 1'b1, 1'b1, 3'd1};
        pk_tab[7] = '{3'b101, 3'd1, 1'b1, 1'b1, 3'd2};
        pk_tab[8] = '{3'b001, 3'd1, 1'b1, 1'b1, 3'd0};
        pk_tab[9] = '{3'b000, 3'd2, 1'b1, 1'b0, 3'd0};

        rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0; sel_i = '0;
        src_int_i = '0; int_ack_i = 1'b0;
        pk_elig = '0; pk_ptr = '0; pk_mode = 1'b0;

        // picker: table vectors
        for (int i = 0; i < 10; i++) begin
            pk_elig = pk_tab[i].elig;
            pk_ptr  = pk_tab[i].ptr;
            pk_mode = pk_tab[i].mode;
            #1;
            chk($sformatf("pk_tab%0d_vld", i), pk_vld, pk_tab[i].vld);
            if (pk_tab[i].vld) chk($sformatf("pk_tab%0d_idx", i), pk_idx, pk_tab[i].idx);
        end
        // picker: random vectors against the reference arbiter
        for (int i = 0; i < 200; i++) begin
            pk_elig = 3'($urandom_range(0, 7));
            pk_ptr  = 3'($urandom_range(0, N - 1));
            pk_mode = 1'($urandom_range(0, 1));
            #1;
            exp_pk = ref_pick(pk_elig, pk_ptr, pk_mode);
            chk($sformatf("pk_rand%0d", i), pk_vld ? {1'b1, pk_idx} : 4'b0, exp_pk);
        end

        // reset state
        tick(); tick();
        rd_chk("rst_data_o", ADDR_CTRL, 0);
        rst = 1'b0;
        chk("rst_req", int_req_o, 0);
        chk("rst_id", int_id_o, 0);
        chk("rst_busy", busy_o, 0);
        rd_chk("rst_mask", ADDR_MASK, 0);
        rd_chk("rst_pend", ADDR_PEND, 0);

        // byte enables and unmapped offsets
        bus_wr(ADDR_MASK, 32'h5, 4'b0001);
        rd_chk("be_mask5", ADDR_MASK, 5);
        bus_wr(ADDR_MASK, 32'hFFFF_FFFF, 4'b0010);
        rd_chk("be_mask_lane1", ADDR_MASK, 5);
        bus_wr(ADDR_CTRL, 32'hFFFF_FFFF, 4'b1110);
        rd_chk("be_ctrl_lanes", ADDR_CTRL, 0);
        bus_wr(5'h14, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("unmapped_14", 5'h14, 0);
        rd_chk("unmapped_1c", 5'h1C, 0);

        // fixed priority
        bus_wr(ADDR_CTRL, 32'h1, 4'b0001);
        bus_wr(ADDR_MASK, 32'h7, 4'b0001);
        pulse(3'b110);
        chk("fx_early_req", int_req_o, 0);
        rd_chk("fx_pend", ADDR_PEND, 6);
        tick();
        chk("fx_req", int_req_o, 1);
        chk("fx_id", int_id_o, 2);
        ack_cycle();
        chk("fx_srv_busy", busy_o, 1);
        chk("fx_srv_req", int_req_o, 0);
        chk("fx_srv_id", int_id_o, 2);
        rd_chk("fx_claim", ADDR_CLAIM, 2);
        rd_chk("fx_pend_after_ack", ADDR_PEND, 4);
        eoi();
        chk("fx_gap_req", int_req_o, 0);
        chk("fx_gap_busy", busy_o, 0);
        tick();
        chk("fx_req2", int_req_o, 1);
        chk("fx_id2", int_id_o, 3);
        eoi();
        chk("fx_eoi_in_req", int_req_o, 1);
        ack_cycle();
        eoi();
        ack_cycle();
        chk("fx_ack_idle_busy", busy_o, 0);
        chk("fx_ack_idle_req", int_req_o, 0);

        // round robin
        bus_wr(ADDR_CTRL, 32'h3, 4'b0001);
        pulse(3'b001);
        wait_req("rr_first", 1);
        ack_cycle();
        eoi();
        pulse(3'b111);
        wait_req("rr_g1", 2);
        ack_cycle();
        eoi();
        wait_req("rr_g2", 3);
        ack_cycle();
        eoi();
        wait_req("rr_g3", 1);
        ack_cycle();
        eoi();
        cleanup();

        // W1C race while requesting
        bus_wr(ADDR_CTRL, 32'h1, 4'b0001);
        pulse(3'b001);
        tick();
        chk("w1c_req_before", int_req_o, 1);
        bus_wr(ADDR_PEND, 32'h1, 4'b0001);
        chk("w1c_req_drop", int_req_o, 0);
        chk("w1c_id", int_id_o, 0);
        chk("w1c_busy", busy_o, 0);
        rd_chk("w1c_claim", ADDR_CLAIM, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (int_req_o) seen = 1'b1;
        end
        chk("w1c_no_rereq", seen, 0);

        // masking while requesting
        pulse(3'b010);
        tick();
        chk("msk_req_id", int_id_o, 2);
        bus_wr(ADDR_MASK, 32'h5, 4'b0001);
        chk("msk_req_drop", int_req_o, 0);
        rd_chk("msk_pend_kept", ADDR_PEND, 2);
        bus_wr(ADDR_MASK, 32'h7, 4'b0001);
        wait_req("msk_rereq", 2);
        ack_cycle();
        eoi();
        cleanup();

        // set wins over W1C
        we_i = 1'b1; addr_i = {27'b0, ADDR_PEND}; data_i = 32'h1; sel_i = 4'b0001;
        src_int_i = 3'b001;
        tick();
        we_i = 1'b0; sel_i = '0; src_int_i = '0;
        rd_chk("setwins_pend", ADDR_PEND, 1);
        bus_wr(ADDR_PEND, 32'h1, 4'b0001);
        rd_chk("w1c_clears", ADDR_PEND, 0);

        // edge on the acked source in the ack cycle
        bus_wr(ADDR_CTRL, 32'h1, 4'b0001);
        pulse(3'b001);
        tick();
        chk("ackedge_id", int_id_o, 1);
        int_ack_i = 1'b1; src_int_i = 3'b001;
        tick();
        int_ack_i = 1'b0; src_int_i = '0;
        chk("ackedge_busy", busy_o, 1);
        rd_chk("ackedge_pend", ADDR_PEND, 1);
        eoi();
        wait_req("ackedge_again", 1);
        ack_cycle();
        eoi();

        // reset mid-service
        pulse(3'b001);
        tick();
        ack_cycle();
        pulse(3'b100);
        chk("rms_busy", busy_o, 1);
        rd_chk("rms_pend", ADDR_PEND, 4);
        rst = 1'b1;
        tick();
        rd_chk("rms_data_in_rst", ADDR_PEND, 0);
        rst = 1'b0;
        chk("rms_busy0", busy_o, 0);
        chk("rms_id0", int_id_o, 0);
        chk("rms_req0", int_req_o, 0);
        rd_chk("rms_pend0", ADDR_PEND, 0);
        bus_wr(ADDR_CTRL, 32'h1, 4'b0001);
        bus_wr(ADDR_MASK, 32'h7, 4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int_req_o) seen = 1'b1;
        end
        chk("rms_no_req", seen, 0);
        pulse(3'b010);
        tick();
        chk("rms_new_req", int_req_o, 1);
        chk("rms_new_id", int_id_o, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_irq_sched.md
Name: timer_irq_sched

Overview:
- Interrupt scheduler between the timer peripheral's interrupt outputs and the core's single external-interrupt input.
- Edge-captures each timer interrupt into a pending latch and applies per-source masking.
- Picks one source by fixed or round-robin priority and presents it to the core with a source ID. It then holds that source until the core acknowledges and signals end-of-interrupt.
- Software configures and services it through the same memory-mapped register bus used by the peripherals.

Parameters:
- NUM_SRC, 3, number of interrupt sources (timer0..timer2); legal 2..8
- ID_W, 3, width of source ID field; must satisfy 2^ID_W > NUM_SRC (ID 0 = none)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- we_i  input  1  register write enable
- addr_i  input  32  register address; block decodes addr_i[4:0]
- data_i  input  32  write data
- sel_i  input  4  byte enables for writes
- data_o  output  32  read data, combinational from addr_i
- src_int_i  input  NUM_SRC  level interrupt inputs (bit n = timer n)
- int_req_o  output  1  interrupt request to core
- int_id_o  output  ID_W  ID of requested/active source (n+1), 0 when none
- int_ack_i  input  1  core accepted the request (single-cycle pulse)
- busy_o  output  1  a source is being serviced (state SERVE)

Behaviour:
- Reset: all registers cleared, state IDLE, rr_ptr=0. Outputs int_req_o=0, int_id_o=0, busy_o=0; data_o=0 while rst is high.
- Registers (word offsets; a byte lane is written only if its sel_i bit is set):
  - 0x00 CTRL: [0] global enable, [1] rr mode (0 = fixed, lowest index wins). RW.
  - 0x04 MASK: [NUM_SRC-1:0], 1 = source enabled. RW.
  - 0x08 PEND: pending bits. Read returns the bits; writing 1 clears a bit (W1C).
  - 0x0C CLAIM: RO, returns active ID (0 if none). Reading has no side effect.
  - 0x10 EOI: any write with sel_i[0]=1 ends service.
  - Other offsets read 0; writes to them are ignored.
- Edge capture: src_q <= src_int_i each cycle. A rising edge (src_int_i & ~src_q) sets PEND[n] on the next clk. Pending is captured regardless of MASK.
- Same-cycle edge and W1C clear on one bit: set wins.
- eligible = PEND & MASK, and only when CTRL[0]=1.
- Arbitration:
  - Fixed mode: lowest set index of eligible.
  - RR mode: first set index at or after rr_ptr, wrapping modulo NUM_SRC.
  - The winner is sampled only in IDLE.
- FSM:
  - IDLE: if eligible != 0, latch winner into act_id and go to REQ next cycle. Latency from the PEND set to int_req_o is 1 cycle.
  - REQ: int_req_o=1, int_id_o=act_id. On int_ack_i: clear PEND[act_id-1] and go to SERVE. If the core takes the ack and an edge arrives on the same source in the same cycle, the edge re-sets the bit (set wins).
  - REQ: if the active source becomes ineligible before ack (masked, W1C, or CTRL[0] cleared), drop the request and return to IDLE with act_id=0. No ack is expected afterwards.
  - SERVE: int_req_o=0, busy_o=1, int_id_o=act_id. An EOI write returns to IDLE, sets act_id=0, and sets rr_ptr to (act_id % NUM_SRC), i.e. the index after the serviced source, wrapping.
  - An EOI in IDLE or REQ is ignored. int_ack_i outside REQ is ignored.
  - New edges during SERVE only accumulate in PEND; there is no preemption.
- At least one IDLE cycle between successive services, so int_req_o has a minimum 1-cycle low gap.
- rst mid-service returns to IDLE immediately and clears pending; no EOI is required.

Decomposition:
- Shared package/defines header: register offsets (CTRL/MASK/PEND/CLAIM/EOI), FSM state encodings (IDLE=2'd0, REQ=2'd1, SERVE=2'd2), and INT_ASSERT/INT_DEASSERT values.
- One natural sub-module: irq_rr_picker. It is combinational and takes the eligible vector, rr_ptr and mode, and returns the winner index and a valid flag. The bench unit-tests it separately.

Test Plan:
- Fixed priority:
  - Setup: CTRL=0x1, MASK=0x7; pulse src_int_i=3'b110 in one cycle.
  - Required: PEND=0x6; int_req_o rises 2 cycles after the edge with int_id_o=2.
  - After ack, then EOI: int_req_o returns with int_id_o=3.
- Round robin:
  - Setup: CTRL=0x3; service ID 1, then hold all three pending.
  - Required: the next grants are IDs 2, 3, 1 in that order.
- Mask/W1C race:
  - Stimulus: in REQ with id=1, write PEND=0x1.
  - Required: int_req_o drops the next cycle, state is IDLE, CLAIM reads 0, no ack is needed.
- Set-wins collision:
  - Stimulus: a W1C of bit0 and a rising edge on src 0 in the same cycle.
  - Required: PEND[0]=1 afterwards.
- Byte enables and unmapped reads:
  - Stimulus: write MASK with data 0xFFFFFFFF and sel_i=4'b0010.
  - Required: MASK unchanged (bits [2:0] live in byte 0); a read of 0x14 returns 0.
- Reset mid-service:
  - Stimulus: in SERVE with PEND=0x4, assert rst for 1 cycle.
  - Required: busy_o=0, PEND=0, int_id_o=0, and no request until a new edge arrives.
